// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_REQ byte producers.
// Optional macro UART_TX_ARBITER_PACKET_LOCK_EN keeps the grant on one requester until it sends 8'h0A.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int GRANT_W = $clog2(N_REQ)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [8*N_REQ-1:0] i_data,
  output logic [N_REQ-1:0]   o_ack,
  output logic [N_REQ-1:0]   o_grant,
  output logic               o_active,
  output logic               o_write,
  output logic [7:0]         o_data,
  input  logic               i_busy
);

  // state        | meaning
  // IDLE         | wait for uart_tx to drain, then pick the next requester
  // ISSUE        | first o_write cycle for the latched byte
  // WAIT_BUSY_HI | o_write held until uart_tx reports busy (byte captured)
  // WAIT_BUSY_LO | byte acked, wait for uart_tx to finish shifting
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY_HI, WAIT_BUSY_LO} state_t;

  state_t             state_q, state_d;
  logic [GRANT_W-1:0] ptr_q, ptr_d;
  logic [GRANT_W-1:0] idx_q, idx_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               active_q, active_d;
  logic [7:0]         data_q, data_d;

  logic               found;
  logic [GRANT_W-1:0] sel_idx;
  logic [GRANT_W-1:0] cand_idx;
  int                 cand;
  logic               pick_valid;
  logic [GRANT_W-1:0] pick_idx;

`ifdef UART_TX_ARBITER_PACKET_LOCK_EN
  logic lock_q, lock_d;
`endif

  // First requesting index strictly after the last grant, wrapping modulo N_REQ.
  always_comb begin
    found    = 1'b0;
    sel_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand     = (int'(ptr_q) + i) % N_REQ;
      cand_idx = GRANT_W'(cand);
      if (!found && i_req[cand_idx]) begin
        found   = 1'b1;
        sel_idx = cand_idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    grant_d    = grant_q;
    active_d   = active_q;
    data_d     = data_q;
    pick_valid = found;
    pick_idx   = sel_idx;
    o_write    = 1'b0;
    o_ack      = '0;
`ifdef UART_TX_ARBITER_PACKET_LOCK_EN
    lock_d     = lock_q;
`endif

    case (state_q)
      IDLE: begin
`ifdef UART_TX_ARBITER_PACKET_LOCK_EN
        if (lock_q) begin
          if (i_req[idx_q]) begin
            pick_valid = 1'b1;
            pick_idx   = idx_q;
          end else begin
            lock_d = 1'b0;
          end
        end
`endif
        if (!i_busy && pick_valid) begin
          idx_d    = pick_idx;
          grant_d  = N_REQ'(1) << pick_idx;
          active_d = 1'b1;
          data_d   = i_data[{pick_idx, 3'b000} +: 8];
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        o_write = 1'b1;
        state_d = WAIT_BUSY_HI;
      end
      WAIT_BUSY_HI: begin
        // uart_tx only samples on its strobe, so busy is the capture indication
        if (i_busy) begin
          o_ack   = grant_q;
          ptr_d   = idx_q;
          state_d = WAIT_BUSY_LO;
`ifdef UART_TX_ARBITER_PACKET_LOCK_EN
          lock_d  = (data_q != 8'h0A);
`endif
        end else begin
          o_write = 1'b1;
        end
      end
      WAIT_BUSY_LO: begin
        if (!i_busy) begin
          grant_d  = '0;
          active_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (i_reset) begin
      o_write = 1'b0;
      o_ack   = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      ptr_q    <= GRANT_W'(N_REQ - 1);
      idx_q    <= '0;
      grant_q  <= '0;
      active_q <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      grant_q  <= grant_d;
      active_q <= active_d;
      data_q   <= data_d;
    end
  end

`ifdef UART_TX_ARBITER_PACKET_LOCK_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) lock_q <= 1'b0;
    else         lock_q <= lock_d;
  end
`endif

  assign o_grant  = grant_q;
  assign o_active = active_q;
  assign o_data   = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a simple uart_tx busy model.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [8*N-1:0] data;
  logic [N-1:0]   ack, grant;
  logic           active, write;
  logic [7:0]     odata;
  logic           busy = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N)) dut (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_data(data),
    .o_ack(ack), .o_grant(grant), .o_active(active), .o_write(write),
    .o_data(odata), .i_busy(busy)
  );

  // uart_tx model: busy rises bdly+1 edges after o_write is first seen, stays high blen cycles
  int bdly = 3, blen = 20, dly_cnt = 0, hold_cnt = 0;
  always @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0; dly_cnt <= 0; hold_cnt <= 0;
    end else if (busy) begin
      if (hold_cnt <= 1) busy <= 1'b0;
      else hold_cnt <= hold_cnt - 1;
    end else if (dly_cnt != 0) begin
      if (dly_cnt == 1) begin busy <= 1'b1; hold_cnt <= blen; end
      dly_cnt <= dly_cnt - 1;
    end else if (write) begin
      dly_cnt <= bdly;
    end
  end

  typedef struct { logic [N-1:0] ack; logic [7:0] data; } exp_t;
  exp_t expq[$];
  exp_t mon_e;
  int n_checks = 0, n_errors = 0, ack_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [7:0] d);
    exp_t t;
    t.ack = '0; t.ack[k] = 1'b1; t.data = d;
    expq.push_back(t);
  endtask

  always @(negedge clk) begin
    if (!rst && ack != '0) begin
      ack_cnt++;
      if (expq.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_ack: got ack=%b data=%h expected none", ack, odata);
      end else begin
        mon_e = expq.pop_front();
        check("ack_onehot", ack, mon_e.ack);
        check("ack_data", odata, mon_e.data);
      end
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic wait_acks(input int target);
    int c = 0;
    while (ack_cnt < target && c < 2000) begin step(); c++; end
    if (ack_cnt < target) check("ack_timeout", ack_cnt, target);
  endtask

  task automatic wait_grant(input logic [N-1:0] g);
    int c = 0;
    while (grant !== g && c < 200) begin step(); c++; end
    check("grant_wait", grant, g);
  endtask

  task automatic wait_idle();
    int c = 0;
    while ((active || busy) && c < 500) begin step(); c++; end
    check("idle_wait", {active, busy}, 0);
  endtask

  localparam logic [8*N-1:0] DATA0 = {8'h44, 8'h43, 8'h42, 8'h41};

  initial begin
    int base, wcnt;
    logic got, prev_busy;
    rst = 1'b1; req = 4'b1111; data = DATA0;

    // reset with all requests asserted
    push(0, 8'h41); push(1, 8'h42); push(2, 8'h43); push(3, 8'h44); push(0, 8'h41);
    repeat (3) step();
    check("rst_grant", grant, 0); check("rst_ack", ack, 0); check("rst_active", active, 0);
    check("rst_write", write, 0); check("rst_data", odata, 0);
    rst = 1'b0;
    check("post_rst_grant", grant, 0); check("post_rst_write", write, 0);
    check("post_rst_active", active, 0);
    step();
    check("first_grant", grant, 4'b0001); check("first_data", odata, 8'h41);
    check("first_active", active, 1); check("issue_write", write, 1);
    wait_acks(5);
    req = '0;
    wait_idle();

    // slow strobe: busy rises 16 cycles after ISSUE
    bdly = 15; blen = 4;
    data[7:0] = 8'h55; push(0, 8'h55); req = 4'b0001;
    wcnt = 0; got = 1'b0; prev_busy = busy;
    for (int c = 0; c < 200 && !got; c++) begin
      step();
      if (ack != '0) begin
        got = 1'b1;
        check("slow_ack_write_low", write, 0);
        check("slow_ack_busy_high", busy, 1);
        check("slow_prev_busy_low", prev_busy, 0);
      end else if (write) begin
        wcnt++;
      end
      prev_busy = busy;
    end
    check("slow_ack_seen", got, 1);
    check("slow_write_cycles", wcnt, 16);
    req = '0;
    wait_idle();

    // single requester 2, back-to-back
    bdly = 3; blen = 5; base = ack_cnt;
    data[23:16] = 8'h10;
    push(2, 8'h10); push(2, 8'h11); push(2, 8'h12);
    req = 4'b0100;
    wait_acks(base + 1); data[23:16] = 8'h11;
    wait_acks(base + 2); data[23:16] = 8'h12;
    wait_acks(base + 3); req = '0;
    wait_idle();
    data = DATA0;

    // reset during WAIT_BUSY_LO after granting requester 1
    bdly = 2; blen = 30; base = ack_cnt;
    push(1, 8'h42); req = 4'b0010;
    wait_acks(base + 1); req = '0;
    repeat (3) step();
    check("pre_abort_active", active, 1);
    rst = 1'b1;
    step();
    check("abort_grant", grant, 0); check("abort_write", write, 0);
    check("abort_active", active, 0); check("abort_ack", ack, 0);
    rst = 1'b0;
    bdly = 3; blen = 6; base = ack_cnt;
    push(0, 8'h41); req = 4'b1111;
    wait_acks(base + 1); req = '0;
    wait_idle();

    // requester 1 sends "HI\n" while 0 and 2 also request
    base = ack_cnt;
    data[15:8] = 8'h48;
`ifdef UART_TX_ARBITER_PACKET_LOCK_EN
    push(1, 8'h48); push(1, 8'h49); push(1, 8'h0A); push(2, 8'h43);
    req = 4'b0010;
    wait_grant(4'b0010);
    req = 4'b0111;
    wait_acks(base + 1); data[15:8] = 8'h49;
    wait_acks(base + 2); data[15:8] = 8'h0A;
    wait_acks(base + 3); req = 4'b0101;
    wait_acks(base + 4); req = '0;
`else
    push(1, 8'h48); push(2, 8'h43); push(0, 8'h41); push(1, 8'h49);
    req = 4'b0010;
    wait_grant(4'b0010);
    req = 4'b0111;
    wait_acks(base + 1); data[15:8] = 8'h49;
    wait_acks(base + 4); req = '0;
`endif
    wait_idle();
    repeat (3) step();
    check("queue_empty", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx transmitter between N byte-producing requesters using round-robin arbitration.
- Sits between the data sources and uart_tx, in place of the direct `transmit = !busy` tie-off.
- Sequences the write/busy handshake with a transmitter clocked by the slower uart_clock strobe.
- Returns a one-cycle acknowledge to the requester whose byte was captured.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- GRANT_W, $clog2(N_REQ), width of the grant index; derived, do not override.

Ports:
- i_clk  in  1  system clock, same domain as uart_clock input.
- i_reset  in  1  synchronous, active-high reset.
- i_req  in  N_REQ  per-requester byte-valid; held high with stable data until acked.
- i_data  in  8*N_REQ  packed bytes; requester k occupies [8k+7:8k].
- o_ack  out  N_REQ  one-hot, one-cycle pulse when requester k's byte has been captured by uart_tx.
- o_grant  out  N_REQ  one-hot current owner; zero when idle.
- o_active  out  1  high while a byte transfer is in progress.
- o_write  out  1  to uart_tx i_write.
- o_data  out  8  to uart_tx i_data; registered copy of the granted byte.
- i_busy  in  1  from uart_tx o_busy.

Behaviour:
- Reset: synchronous, active-high; the polarity and synchronicity are fixed. During reset and on the first cycle after it, outputs are:
  - o_ack=0, o_grant=0, o_active=0, o_write=0, o_data=8'h00.
  - state=IDLE.
  - last-grant pointer = N_REQ-1, so requester 0 wins first.
- Reset mid-transfer aborts immediately. The in-flight uart byte is not tracked, and no ack is issued for it.
- FSM states: IDLE, ISSUE, WAIT_BUSY_HI, WAIT_BUSY_LO.
- IDLE:
  - If i_busy=1, stay in IDLE (transmitter still draining).
  - Else, if any i_req: select the first set bit scanning from pointer+1 upward, wrapping modulo N_REQ.
  - Register o_grant, register o_data from that slice, set o_active, go to ISSUE next cycle.
  - Decision-to-ISSUE latency is 1 cycle.
- ISSUE: o_write=1 for one cycle, then go to WAIT_BUSY_HI.
- WAIT_BUSY_HI:
  - Hold o_write=1 until i_busy=1; uart_tx samples only on a uart_clk strobe, which may be many i_clk later.
  - On the cycle i_busy is first seen high: drop o_write, pulse o_ack[grant], update pointer to the grant index, go to WAIT_BUSY_LO.
- WAIT_BUSY_LO:
  - When i_busy=0: clear o_grant and o_active, return to IDLE.
  - Minimum gap between transfers is 1 idle cycle.
- Request withdrawal: i_req dropping after the grant is ignored. The latched byte is still sent and acked, and the requester must tolerate the ack.
- Simultaneous requests: strictly round-robin. No requester wins twice while another requester stays asserted.
- Single requester: may win back-to-back.
- o_data is stable from ISSUE until return to IDLE.
- Byte values are not interpreted, except under the optional feature.

Optional Feature:
- Macro: UART_TX_ARBITER_PACKET_LOCK_EN.
- Defined:
  - After a byte is acked, the pointer is not advanced and grant stays locked to the same requester while it keeps i_req high.
  - The lock ends when the acked byte equals 8'h0A, or when the owner's i_req is low in IDLE; only then does round-robin resume.
  - Adds a 1-bit lock flag, cleared by reset.
  - Keeps newline-terminated messages unbroken.
- Undefined: plain per-byte round-robin, as described in Behaviour.

Test Plan:
- Reset with i_req=4'b1111 held: all outputs 0 through reset; first grant=4'b0001, o_data=i_data[7:0]=8'h41.
- All four requesting, busy model high 3 cycles after o_write and low 20 cycles later: ack order 0,1,2,3,0; exactly one o_ack pulse per transfer.
- Slow uart strobe (busy rises 16 cycles after ISSUE): o_write held high all 16 cycles; ack exactly on the i_busy-rise cycle.
- Only requester 2 active with bytes 8'h10, 8'h11, 8'h12: three consecutive grants to 2; o_data sequence matches.
- i_reset asserted while in WAIT_BUSY_LO: next cycle o_grant=0, o_write=0, no ack; the next arbitration starts from requester 0.
- With UART_TX_ARBITER_PACKET_LOCK_EN defined, requester 1 sends "HI\n" while 0 and 2 request: bytes 8'h48, 8'h49, 8'h0A go out contiguously, then grant moves to 2.
